ahb3lite_sram_arbiter: RTL and testbench

- Two-requester AHB3-Lite master that shares the single-port SRAM slave (ahb3lite_sram1rw) between two on-chip clients.
- Each client uses a simple req/gnt/done interface. The block arbitrates round-robin, drives pipelined SINGLE/NONSEQ transfers and returns read data and error status per client.
- Sits between the clients and the slave's AHB port. There is only one slave, so HREADY is looped back from HREADYOUT.

---
 rtl/ahb3lite_sram_arbiter_if.sv | 39 +++
 rtl/ahb3lite_sram_arbiter.sv | 99 +++++++++
 tb/tb_ahb3lite_sram_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb3lite_sram_arbiter_if.sv
// ahb3lite_sram_arbiter_if: client req/gnt/done handshakes plus the AHB3-Lite master port of the arbiter
interface ahb3lite_sram_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req0, req1;
  logic                  we0, we1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [2:0]            size0, size1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  gnt0, gnt1;
  logic                  done0, done1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;
  logic                  err0, err1;
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [1:0]            HTRANS;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic [DATA_WIDTH-1:0] HRDATA;
  logic                  HREADYOUT;
  logic                  HRESP;
  modport master (
    input  req0, req1, we0, we1, addr0, addr1, size0, size1, wdata0, wdata1,
    output gnt0, gnt1, done0, done1, rdata0, rdata1, err0, err1,
    output HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );
  modport slave (
    output req0, req1, we0, we1, addr0, addr1, size0, size1, wdata0, wdata1,
    input  gnt0, gnt1, done0, done1, rdata0, rdata1, err0, err1,
    input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb3lite_sram_arbiter.sv
// ahb3lite_sram_arbiter: round-robin two-client AHB3-Lite master in front of a single SRAM slave
module ahb3lite_sram_arbiter #(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
  input logic HCLK,
  input logic HRESETn,
  ahb3lite_sram_arbiter_if.master bus
);
  localparam int BYTES = DATA_WIDTH / 8;
  logic                  last;
  logic                  hold_v, hold_own, hold_we;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [2:0]            hold_size;
  logic                  block;
  logic                  dp_v, dp_own, dp_we;
  logic                  bad_v, bad_own;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  any, own, s_we, ok, nonseq, gnt_bus, gnt_bad, dp_done;
  logic [ADDR_WIDTH-1:0] s_addr;
  logic [2:0]            s_size;

  function automatic logic size_ok(input logic [2:0] s);
    return (s <= 3'd2) && ((1 << s) <= BYTES);
  endfunction

  // Address-phase selection: a held phase wins, otherwise round-robin over live requests.
  // The cycle after the first ERROR cycle is forced idle so the cancelled request re-arbitrates.
  always_comb begin
    any    = hold_v || (!block && (bus.req0 || bus.req1));
    own    = hold_v ? hold_own : (bus.req0 && bus.req1) ? !last : bus.req1;
    s_we   = hold_v ? hold_we : own ? bus.we1 : bus.we0;
    s_addr = hold_v ? hold_addr : own ? bus.addr1 : bus.addr0;
    s_size = hold_v ? hold_size : own ? bus.size1 : bus.size0;
    ok      = hold_v || size_ok(s_size);
    nonseq  = HRESETn && any && ok;
    gnt_bus = nonseq && bus.HREADYOUT;
    gnt_bad = HRESETn && any && !ok && bus.HREADYOUT;
    dp_done = dp_v && bus.HREADYOUT;
  end

  assign bus.HSEL   = nonseq;
  assign bus.HTRANS = nonseq ? 2'b10 : 2'b00;
  assign bus.HADDR  = nonseq ? s_addr : '0;
  assign bus.HWRITE = nonseq && s_we;
  assign bus.HSIZE  = nonseq ? s_size : 3'b000;
  assign bus.HBURST = 3'b000;
  assign bus.HPROT  = HPROT_VAL;
  assign bus.HWDATA = hwdata;
  assign bus.HREADY = bus.HREADYOUT;
  assign bus.gnt0   = (gnt_bus || gnt_bad) && !own;
  assign bus.gnt1   = (gnt_bus || gnt_bad) && own;
  assign bus.done0  = (dp_done && !dp_own) || (bad_v && !bad_own);
  assign bus.done1  = (dp_done && dp_own) || (bad_v && bad_own);
  assign bus.err0   = (dp_done && !dp_own && bus.HRESP) || (bad_v && !bad_own);
  assign bus.err1   = (dp_done && dp_own && bus.HRESP) || (bad_v && bad_own);
  assign bus.rdata0 = (dp_done && !dp_own && !dp_we) ? bus.HRDATA : '0;
  assign bus.rdata1 = (dp_done && dp_own && !dp_we) ? bus.HRDATA : '0;

  // Address hold, error cancel, round-robin pointer, data-phase tracking and write data capture
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      last      <= 1'b1;
      hold_v    <= 1'b0;
      hold_own  <= 1'b0;
      hold_we   <= 1'b0;
      hold_addr <= '0;
      hold_size <= 3'b000;
      block     <= 1'b0;
      dp_v      <= 1'b0;
      dp_own    <= 1'b0;
      dp_we     <= 1'b0;
      bad_v     <= 1'b0;
      bad_own   <= 1'b0;
      hwdata    <= '0;
    end else begin
      block  <= dp_v && bus.HRESP && !bus.HREADYOUT;
      hold_v <= nonseq && !bus.HREADYOUT && !bus.HRESP;
      if (!hold_v) begin
        hold_own  <= own;
        hold_we   <= s_we;
        hold_addr <= s_addr;
        hold_size <= s_size;
      end
      bad_v   <= gnt_bad;
      bad_own <= own;
      if (gnt_bus || gnt_bad) last <= own;
      if (gnt_bus) begin
        dp_v   <= 1'b1;
        dp_own <= own;
        dp_we  <= s_we;
        hwdata <= own ? bus.wdata1 : bus.wdata0;
      end else if (dp_done) begin
        dp_v <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ahb3lite_sram_arbiter.sv
// tb_ahb3lite_sram_arbiter: directed and randomized checks of the arbiter against a SRAM slave model and a grant-order reference
module tb_ahb3lite_sram_arbiter;
  logic clk, rstn;
  int nvec, nerr;
  int ws_cfg;
  logic [31:0] err_addr;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic s_v, s_wr, s_err, s_err2;
  logic [31:0] s_addr;
  int s_cnt;
  logic op_we [2][8];
  logic [31:0] op_ad [2][8];
  logic [31:0] op_wd [2][8];
  int i0, i1, k;
  logic r0, r1, anyr, win, rr_last, pv, pown, prd;
  logic [31:0] pdata;

  ahb3lite_sram_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  ahb3lite_sram_arbiter dut (.HCLK(clk), .HRESETn(rstn), .bus(bus.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] f(input int i);
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A5A5A;
  endfunction

  assign bus.HREADYOUT = !s_v || (s_cnt == 0 && (!s_err || s_err2));
  assign bus.HRESP     = s_v && s_cnt == 0 && s_err;
  assign bus.HRDATA    = s_v ? mem[s_addr[7:2]] : 32'h0;

  // SRAM slave model with programmable wait states and a two-cycle ERROR on one address
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s_v <= 1'b0; s_wr <= 1'b0; s_err <= 1'b0; s_err2 <= 1'b0; s_cnt <= 0; s_addr <= 32'h0;
      for (int i = 0; i < 64; i++) mem[i] <= f(i);
    end else if (s_v && s_cnt != 0) begin
      s_cnt <= s_cnt - 1;
    end else if (s_v && s_err && !s_err2) begin
      s_err2 <= 1'b1;
    end else begin
      if (s_v && s_wr && !s_err) mem[s_addr[7:2]] <= bus.HWDATA;
      s_v    <= bus.HSEL && bus.HTRANS == 2'b10;
      s_addr <= bus.HADDR;
      s_wr   <= bus.HWRITE;
      s_cnt  <= ws_cfg;
      s_err  <= bus.HADDR == err_addr;
      s_err2 <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 32'h0; bus.size0 = 3'd2; bus.wdata0 = 32'h0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 32'h0; bus.size1 = 3'd2; bus.wdata1 = 32'h0;
  endtask

  initial begin
    nvec = 0; nerr = 0; ws_cfg = 0; err_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 64; i++) ref_mem[i] = f(i);
    rstn = 1'b0;
    idle();
    bus.req0 = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_htrans", bus.HTRANS, 0);
    chk("rst_hsel", bus.HSEL, 0);
    chk("rst_haddr", bus.HADDR, 0);
    chk("rst_hwdata", bus.HWDATA, 0);
    chk("rst_gnt0", bus.gnt0, 0);
    chk("rst_done0", bus.done0, 0);
    rstn = 1'b1;
    idle();

    @(negedge clk);
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h10; bus.wdata0 = 32'hDEADBEEF;
    #1;
    chk("wr_gnt0", bus.gnt0, 1);
    chk("wr_htrans", bus.HTRANS, 2'b10);
    chk("wr_haddr", bus.HADDR, 32'h10);
    chk("wr_hwrite", bus.HWRITE, 1);
    ref_mem[4] = 32'hDEADBEEF;
    @(negedge clk);
    idle();
    #1;
    chk("wr_hwdata", bus.HWDATA, 32'hDEADBEEF);
    chk("wr_done0", bus.done0, 1);
    chk("wr_err0", bus.err0, 0);

    for (int c = 0; c < 2; c++)
      for (int j = 0; j < 8; j++) begin
        op_we[c][j] = 1'($urandom_range(0, 1));
        op_ad[c][j] = 32'($urandom_range(0, 63)) << 2;
        op_wd[c][j] = $urandom;
      end
    i0 = 0; i1 = 0; pv = 1'b0; pown = 1'b0; prd = 1'b0; pdata = 32'h0; rr_last = 1'b0;
    for (int cyc = 0; cyc < 40 && (i0 < 8 || i1 < 8 || pv); cyc++) begin
      @(negedge clk);
      r0 = i0 < 8; r1 = i1 < 8;
      idle();
      bus.req0 = r0; bus.req1 = r1;
      if (r0) begin bus.we0 = op_we[0][i0]; bus.addr0 = op_ad[0][i0]; bus.wdata0 = op_wd[0][i0]; end
      if (r1) begin bus.we1 = op_we[1][i1]; bus.addr1 = op_ad[1][i1]; bus.wdata1 = op_wd[1][i1]; end
      anyr = r0 || r1;
      win  = (r0 && r1) ? !rr_last : r1;
      k    = win ? i1 : i0;
      #1;
      chk("rr_gnt0", bus.gnt0, anyr && !win);
      chk("rr_gnt1", bus.gnt1, anyr && win);
      chk("rr_done0", bus.done0, pv && !pown);
      chk("rr_done1", bus.done1, pv && pown);
      chk("rr_burst_prot", {bus.HBURST, bus.HPROT}, 7'b000_0011);
      if (pv && prd) chk("rr_rdata", pown ? bus.rdata1 : bus.rdata0, pdata);
      if (pv && !prd) chk("rr_hwdata", bus.HWDATA, pdata);
      if (anyr) chk("rr_haddr", bus.HADDR, op_ad[win][k]);
      pv = anyr;
      if (anyr) begin
        pown = win;
        prd  = !op_we[win][k];
        if (prd) pdata = ref_mem[op_ad[win][k] >> 2];
        else begin pdata = op_wd[win][k]; ref_mem[op_ad[win][k] >> 2] = pdata; end
        rr_last = win;
        if (win) i1++; else i0++;
      end
    end

    @(negedge clk);
    idle();
    ws_cfg = 2;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h20; bus.wdata0 = 32'hCAFE0001;
    #1;
    chk("ws_gnt0", bus.gnt0, 1);
    ref_mem[8] = 32'hCAFE0001;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      idle();
      ws_cfg = 0;
      bus.req1 = 1'b1; bus.addr1 = 32'h24;
      #1;
      chk("ws_haddr", bus.HADDR, 32'h24);
      chk("ws_htrans", bus.HTRANS, 2'b10);
      chk("ws_gnt1_wait", bus.gnt1, 0);
      chk("ws_done0_wait", bus.done0, 0);
    end
    @(negedge clk);
    #1;
    chk("ws_haddr3", bus.HADDR, 32'h24);
    chk("ws_gnt1", bus.gnt1, 1);
    chk("ws_done0", bus.done0, 1);
    chk("ws_hwdata", bus.HWDATA, 32'hCAFE0001);
    @(negedge clk);
    idle();
    #1;
    chk("ws_done1", bus.done1, 1);
    chk("ws_rdata1", bus.rdata1, ref_mem[9]);
    chk("ws_memwr", mem[8], ref_mem[8]);

    @(negedge clk);
    err_addr = 32'h30;
    bus.req0 = 1'b1; bus.addr0 = 32'h30;
    #1;
    chk("er_gnt0", bus.gnt0, 1);
    @(negedge clk);
    idle();
    bus.req1 = 1'b1; bus.addr1 = 32'h34;
    #1;
    chk("er1_htrans", bus.HTRANS, 2'b10);
    chk("er1_hready", bus.HREADY, 0);
    chk("er1_gnt1", bus.gnt1, 0);
    chk("er1_done0", bus.done0, 0);
    @(negedge clk);
    err_addr = 32'hFFFF_FFFF;
    #1;
    chk("er2_htrans", bus.HTRANS, 0);
    chk("er2_gnt1", bus.gnt1, 0);
    chk("er2_done0", bus.done0, 1);
    chk("er2_err0", bus.err0, 1);
    @(negedge clk);
    #1;
    chk("er3_gnt1", bus.gnt1, 1);
    chk("er3_haddr", bus.HADDR, 32'h34);
    @(negedge clk);
    idle();
    #1;
    chk("er4_done1", bus.done1, 1);
    chk("er4_err1", bus.err1, 0);
    chk("er4_rdata1", bus.rdata1, ref_mem[13]);

    @(negedge clk);
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.size1 = 3'b011; bus.addr1 = 32'h40; bus.wdata1 = 32'h12345678;
    #1;
    chk("bs_gnt1", bus.gnt1, 1);
    chk("bs_gnt0", bus.gnt0, 0);
    chk("bs_htrans", bus.HTRANS, 0);
    chk("bs_hsel", bus.HSEL, 0);
    @(negedge clk);
    idle();
    #1;
    chk("bs_done1", bus.done1, 1);
    chk("bs_err1", bus.err1, 1);
    chk("bs_htrans2", bus.HTRANS, 0);
    @(negedge clk);
    #1;
    chk("bs_mem", mem[16], ref_mem[16]);
    chk("bs_done1_off", bus.done1, 0);

    @(negedge clk);
    ws_cfg = 3;
    bus.req0 = 1'b1; bus.addr0 = 32'h50;
    #1;
    chk("rs_gnt0", bus.gnt0, 1);
    @(negedge clk);
    ws_cfg = 0;
    idle();
    bus.req1 = 1'b1; bus.addr1 = 32'h34;
    #1;
    chk("rs_pre_htrans", bus.HTRANS, 2'b10);
    #2;
    rstn = 1'b0;
    #1;
    chk("rs_htrans", bus.HTRANS, 0);
    chk("rs_hsel", bus.HSEL, 0);
    chk("rs_haddr", bus.HADDR, 0);
    chk("rs_hwdata", bus.HWDATA, 0);
    chk("rs_gnt1", bus.gnt1, 0);
    chk("rs_done0", bus.done0, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = f(i);
    bus.req0 = 1'b1; bus.addr0 = 32'h54;
    #1;
    chk("rs_first_gnt0", bus.gnt0, 1);
    chk("rs_first_gnt1", bus.gnt1, 0);
    chk("rs_first_haddr", bus.HADDR, 32'h54);
    @(negedge clk);
    bus.req0 = 1'b0;
    #1;
    chk("rs_next_gnt1", bus.gnt1, 1);
    chk("rs_done0_after", bus.done0, 1);
    chk("rs_rdata0", bus.rdata0, ref_mem[21]);
    @(negedge clk);
    idle();
    #1;
    chk("rs_done1_after", bus.done1, 1);
    chk("rs_rdata1", bus.rdata1, ref_mem[13]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
